// File: rtl/rr_decoder_arbiter.sv
// ---------------------------------------------------------------------------
// rr_decoder_arbiter
//
// Round-robin arbiter that hands one 16-slot shared resource to one of 16
// requesters at a time. The owner index is registered. The one-hot grant is
// a pure decode of that index, so it can never be multi-hot. The owner keeps
// the grant until it signals done or withdraws its request. The next search
// starts just after the previous owner.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   When defined, a grant is force-released after HOLD_MAX cycles. timeout
//   pulses for one cycle, coincident with the grant drop.
//   When undefined, there is no hold counter and timeout is tied low.
//
// Parameters:
//   HOLD_MAX     maximum grant length in cycles with timeout enabled (1..255)
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset_n      synchronous active-low reset
//   req[15:0]    request vector, bit i = requester i wants the resource
//   done         current owner releases (ignored while idle)
//   grant[15:0]  one-hot grant, zero when no grant is active
//   grant_valid  a grant is active
//   grant_id     index of the current / last owner
//   timeout      one-cycle pulse after a forced release
// ---------------------------------------------------------------------------
module rr_decoder_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] req,
    input  logic        done,
    output logic [15:0] grant,
    output logic        grant_valid,
    output logic [3:0]  grant_id,
    output logic        timeout
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_range
        $error("rr_decoder_arbiter: HOLD_MAX must be within 1..255");
    end

    logic       state;
    logic [3:0] ptr;
    logic [3:0] winner;
    logic       winner_found;
    logic [3:0] search_idx;
    logic       release_normal;
    logic       force_release;

    // Circular priority search: ptr, ptr+1, ... wrapping through 15 to 0.
    always_comb begin
        winner       = 4'd0;
        winner_found = 1'b0;
        search_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            search_idx = ptr + 4'(i);
            if (!winner_found && req[search_idx]) begin
                winner_found = 1'b1;
                winner       = search_idx;
            end
        end
    end

    // done and a dropped request have the same effect, alone or together.
    assign release_normal = done || !req[grant_id];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] hold_cnt;
    logic       timeout_r;

    // A normal release in the same cycle wins, so no timeout is reported.
    assign force_release = !release_normal && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_cnt  <= 8'd0;
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= (state == ST_GRANT) && force_release;
            // The count sits at zero while idle, so every grant starts from zero.
            if (state == ST_IDLE) begin
                hold_cnt <= 8'd0;
            end else if (hold_cnt != 8'hFF) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end

    assign timeout = timeout_r;
`else
    assign force_release = 1'b0;
    assign timeout       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            ptr      <= 4'd0;
            grant_id <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (winner_found) begin
                        state    <= ST_GRANT;
                        grant_id <= winner;
                    end
                end
                default: begin
                    // Other requests wait until the arbiter is idle again.
                    // Every handover therefore has one zero-grant cycle.
                    if (release_normal || force_release) begin
                        state <= ST_IDLE;
                        ptr   <= grant_id + 4'd1;
                    end
                end
            endcase
        end
    end

    assign grant_valid = (state == ST_GRANT);
    assign grant       = grant_valid ? (16'd1 << grant_id) : 16'd0;

endmodule

// File: doc/rr_decoder_arbiter.md
# rr_decoder_arbiter

Round-robin arbiter that shares one 16-way one-hot select resource among 16 requesters. Each cycle it tracks a 4-bit winner index. The one-hot grant vector is produced by decoding that index under an enable: `1 << grant_id` when a grant is active, all zeros otherwise. The block sits in front of any 16-slot shared resource (bus, memory bank, chip-select fabric) and sequences ownership. Ownership is held until the owner finishes or withdraws.

## Interface
Parameters:
- HOLD_MAX, default 16: maximum grant length in cycles when timeout is compiled in; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  reset; synchronous and active-low (one clock; reset is synchronous and active-low).
- req  input  16  request vector; bit i = requester i wants the resource.
- done  input  1  current owner releases the grant; ignored when no grant is active.
- grant  output  16  one-hot grant; `grant_valid ? (1 << grant_id) : 16'b0`.
- grant_valid  output  1  a grant is active.
- grant_id  output  4  index of the current owner; holds its last value when idle.
- timeout  output  1  one-cycle pulse when a grant is force-released.

## Operation
- Two states, IDLE and GRANT. A priority pointer `ptr[3:0]` records the search start.
- Reset (reset_n=0 at an edge) sets:
  - state=IDLE, ptr=0, grant_id=0, grant_valid=0, grant=0, timeout=0, hold counter=0.
  - It overrides all other inputs, including a reset that arrives mid-grant.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise the winner is the first set bit searching ptr, ptr+1, …, 15, 0, …, ptr-1 (mod 16).
  - Next state is GRANT with grant_id=winner, grant_valid=1 and counter=0.
- GRANT:
  - Release when done=1 OR req[grant_id]=0.
  - On release: next state is IDLE, grant_valid=0, and ptr = grant_id+1 (4-bit wrap, 15→0). grant_id is held.
  - Other requests seen while in GRANT are not arbitrated until the block returns to IDLE.
- done and req[grant_id] deasserting in the same cycle produce a single release with identical behaviour.
- grant is a pure combinational decode of the registered grant_id and grant_valid. It is never multi-hot and never nonzero when grant_valid=0.
- The hold counter is 8 bits. It increments each cycle in GRANT and saturates at 255.

## Timing
- Request to grant: req sampled at edge N; grant visible after edge N (1-cycle latency).
- Release to grant drop: done or req drop sampled at edge M; grant=0 after edge M.
- Handover always includes at least one IDLE cycle, so back-to-back owners are separated by one zero-grant cycle.
- Minimum grant length is 1 cycle: done asserted in the first GRANT cycle releases at the next edge.
- Fairness: with all 16 requesting continuously and each owner holding 1 cycle, every requester is served once in 32 cycles.

## Configuration
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when counter == HOLD_MAX-1 and no normal release occurs, the block force-releases at that edge (grant lasts exactly HOLD_MAX cycles) and timeout=1 for the following cycle.
  - ptr advances exactly as for a normal release.
  - A normal release in the same cycle takes priority, and timeout stays 0.
- Undefined: no forced release and no counter logic; timeout is tied to 0. A grant persists indefinitely until done or the req drop.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with req=16'hFFFF → grant=0, grant_valid=0, grant_id=0, timeout=0 throughout; first grant after release goes to id 0.
- Single requester: req=16'h0020 → one cycle later grant=16'h0020, grant_id=5. Pulse done for 1 cycle → grant=0 the next cycle; ptr=6 (next search starts at 6).
- Round-robin with wrap: req=16'h8001 held, done pulsed each GRANT cycle → grant_id sequence 0,15,0,15, each grant separated by one grant=0 cycle.
- Withdrawal: grant to id 3, then drop req[3] without done → grant=0 next cycle. With req=16'h0011 pending, the next grant is id 4.
- Timeout (ARB_TIMEOUT_EN, HOLD_MAX=4): req[3] held, done=0 → grant=16'h0008 for exactly 4 cycles, then 0, with timeout=1 for one cycle coincident with the drop. Without the macro, grant stays 16'h0008 for 100+ cycles and timeout stays 0.
- Reset mid-grant: while grant_id=9 is active, assert reset_n=0 for 1 cycle → grant=0 after that edge. After reset_n returns high with req=16'h0200, grant=16'h0200 one cycle later.
